// File: rtl/serial_frame_pkg.sv
// Shared types and constants for the serial frame receiver.
package serial_frame_pkg;

   typedef enum logic {
      HUNT    = 1'b0,
      PAYLOAD = 1'b1
   } state_t;

   localparam logic [7:0]  SYNC_DEFAULT   = 8'hA5;
   localparam int unsigned BYTE_CNT_MAX_W = $clog2(16);
   localparam int unsigned BIT_CNT_W      = 3;
   localparam int unsigned FILL_W         = 4;

   // Byte counter width for a given frame length, never narrower than one bit.
   function automatic int unsigned byte_cnt_w(input int unsigned n_bytes);
      return (n_bytes > 1) ? $clog2(n_bytes) : 1;
   endfunction

endpackage

// File: rtl/serial_frame_rx_sipo_byte.sv
// 8-bit serial-in/parallel-out shifter; o_next_c is the byte formed with the current input bit.
module sipo_byte (
   input  logic       clk,
   input  logic       reset,
   input  logic       i_clear,
   input  logic       i_shift,
   input  logic       i_in,
   output logic [7:0] o_next_c
);

   // Only the seven most recent bits are stored; the eighth is the live input.
   logic [6:0] r_q;

   assign o_next_c = {r_q, i_in};

   always_ff @(posedge clk) begin
      if (reset || i_clear) begin
         r_q <= 7'd0;
      end else if (i_shift) begin
         r_q <= o_next_c[6:0];
      end
   end

endmodule

// File: rtl/serial_frame_rx.sv
// Serial frame receiver: hunts for a sync byte, then deserializes PAYLOAD_BYTES bytes MSB first.
module serial_frame_rx
   import serial_frame_pkg::*;
#(
   parameter logic [7:0]  SYNC          = SYNC_DEFAULT,
   parameter int unsigned PAYLOAD_BYTES = 2
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       in,
   output logic [7:0] data,
   output logic       data_valid,
   output logic       frame_done,
   output logic       locked,
   output logic [7:0] frame_count
);

   localparam int unsigned BYTE_W = byte_cnt_w(PAYLOAD_BYTES);
   localparam logic [BYTE_W-1:0]    LAST_BYTE  = BYTE_W'(PAYLOAD_BYTES - 1);
   localparam logic [FILL_W-1:0]    FILL_FULL  = FILL_W'(8);
   localparam logic [FILL_W-1:0]    FILL_MATCH = FILL_W'(7);
   localparam logic [BIT_CNT_W-1:0] LAST_BIT   = BIT_CNT_W'(7);

   state_t               r_state;
   state_t               w_state_next;
   logic [FILL_W-1:0]    r_fill;
   logic [BIT_CNT_W-1:0] r_bit_cnt;
   logic [BYTE_W-1:0]    r_byte_cnt;

   logic       w_win_shift;
   logic       w_win_clear;
   logic       w_pay_shift;
   logic       w_pay_clear;
   logic       w_sync_hit;
   logic       w_byte_end;
   logic       w_frame_end;
   logic [7:0] w_win_next;
   logic [7:0] w_pay_next;

   sipo_byte u_win (
      .clk      (clk),
      .reset    (reset),
      .i_clear  (w_win_clear),
      .i_shift  (w_win_shift),
      .i_in     (in),
      .o_next_c (w_win_next)
   );

   sipo_byte u_pay (
      .clk      (clk),
      .reset    (reset),
      .i_clear  (w_pay_clear),
      .i_shift  (w_pay_shift),
      .i_in     (in),
      .o_next_c (w_pay_next)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= HUNT;
      end else begin
         r_state <= w_state_next;
      end
   end

   // Next state and per-cycle control strobes.
   always_comb begin
      w_state_next = r_state;
      w_win_shift  = 1'b0;
      w_win_clear  = 1'b0;
      w_pay_shift  = 1'b0;
      w_pay_clear  = 1'b0;
      w_sync_hit   = 1'b0;
      w_byte_end   = 1'b0;
      w_frame_end  = 1'b0;
      case (r_state)
         HUNT: begin
            w_win_shift = 1'b1;
            // Fill guard stops reset zeros from forming a false sync.
            if ((r_fill >= FILL_MATCH) && (w_win_next == SYNC)) begin
               w_sync_hit   = 1'b1;
               w_pay_clear  = 1'b1;
               w_state_next = PAYLOAD;
            end
         end
         PAYLOAD: begin
            w_pay_shift = 1'b1;
            if (r_bit_cnt == LAST_BIT) begin
               w_byte_end = 1'b1;
               if (r_byte_cnt == LAST_BYTE) begin
                  w_frame_end  = 1'b1;
                  w_win_clear  = 1'b1;
                  w_state_next = HUNT;
               end
            end
         end
         default: begin
            w_state_next = HUNT;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_fill      <= '0;
         r_bit_cnt   <= '0;
         r_byte_cnt  <= '0;
         data        <= 8'd0;
         data_valid  <= 1'b0;
         frame_done  <= 1'b0;
         frame_count <= 8'd0;
      end else begin
         data_valid <= w_byte_end;
         frame_done <= w_frame_end;

         if (w_byte_end) begin
            data <= w_pay_next;
         end
         if (w_frame_end) begin
            frame_count <= frame_count + 8'd1;
         end

         if (w_win_clear) begin
            r_fill <= '0;
         end else if (w_win_shift && (r_fill != FILL_FULL)) begin
            r_fill <= r_fill + FILL_W'(1);
         end

         // Bit counter wraps 7 -> 0 on its own at each byte boundary.
         if (w_sync_hit) begin
            r_bit_cnt <= '0;
         end else if (w_pay_shift) begin
            r_bit_cnt <= r_bit_cnt + BIT_CNT_W'(1);
         end

         if (w_sync_hit) begin
            r_byte_cnt <= '0;
         end else if (w_byte_end) begin
            r_byte_cnt <= r_byte_cnt + BYTE_W'(1);
         end
      end
   end

   assign locked = (r_state == PAYLOAD);

endmodule

// File: tb/tb_serial_frame_rx.sv
// Bench for serial_frame_rx: three parameterizations checked against a bit-queue model every cycle.
module tb_serial_frame_rx;

   localparam logic [7:0] SYNC_P [3] = '{8'hA5, 8'h00, 8'hA5};
   localparam int         PB_P   [3] = '{2, 2, 1};

   logic       clk;
   logic       reset;
   logic       in_v        [3];
   logic [7:0] data_w      [3];
   logic       valid_w     [3];
   logic       done_w      [3];
   logic       locked_w    [3];
   logic [7:0] count_w     [3];

   int n_checks = 0;
   int n_fail   = 0;

   serial_frame_rx #(.SYNC(8'hA5), .PAYLOAD_BYTES(2)) u_dut0 (
      .clk(clk), .reset(reset), .in(in_v[0]), .data(data_w[0]), .data_valid(valid_w[0]),
      .frame_done(done_w[0]), .locked(locked_w[0]), .frame_count(count_w[0]));

   serial_frame_rx #(.SYNC(8'h00), .PAYLOAD_BYTES(2)) u_dut1 (
      .clk(clk), .reset(reset), .in(in_v[1]), .data(data_w[1]), .data_valid(valid_w[1]),
      .frame_done(done_w[1]), .locked(locked_w[1]), .frame_count(count_w[1]));

   serial_frame_rx #(.SYNC(8'hA5), .PAYLOAD_BYTES(1)) u_dut2 (
      .clk(clk), .reset(reset), .in(in_v[2]), .data(data_w[2]), .data_valid(valid_w[2]),
      .frame_done(done_w[2]), .locked(locked_w[2]), .frame_count(count_w[2]));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input int idx, input logic [31:0] got,
                        input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s dut%0d at %0t: got %0h expected %0h", name, idx, $time, got, exp);
      end
   endtask

   // Reference model: bits seen while hunting and bits of the current payload, as queues.
   logic       m_hq   [3][$];
   logic       m_pq   [3][$];
   logic       m_lock [3];
   logic [7:0] e_data [3];
   logic       e_valid[3];
   logic       e_done [3];
   logic [7:0] e_cnt  [3];
   bit         m_ready = 1'b0;

   function automatic logic [7:0] last8(input logic q[$]);
      logic [7:0] v = 8'd0;
      for (int j = q.size() - 8; j < q.size(); j++) v = {v[6:0], q[j]};
      return v;
   endfunction

   always @(posedge clk) begin
      for (int i = 0; i < 3; i++) begin
         if (reset) begin
            m_hq[i].delete();
            m_pq[i].delete();
            m_lock[i]  = 1'b0;
            e_data[i]  = 8'd0;
            e_valid[i] = 1'b0;
            e_done[i]  = 1'b0;
            e_cnt[i]   = 8'd0;
            m_ready    = 1'b1;
         end else begin
            e_valid[i] = 1'b0;
            e_done[i]  = 1'b0;
            if (!m_lock[i]) begin
               m_hq[i].push_back(in_v[i]);
               if (m_hq[i].size() > 8) void'(m_hq[i].pop_front());
               if (m_hq[i].size() == 8 && last8(m_hq[i]) == SYNC_P[i]) begin
                  m_lock[i] = 1'b1;
                  m_pq[i].delete();
               end
            end else begin
               m_pq[i].push_back(in_v[i]);
               if (m_pq[i].size() % 8 == 0) begin
                  e_data[i]  = last8(m_pq[i]);
                  e_valid[i] = 1'b1;
                  if (m_pq[i].size() == 8 * PB_P[i]) begin
                     e_done[i] = 1'b1;
                     e_cnt[i]  = e_cnt[i] + 8'd1;
                     m_lock[i] = 1'b0;
                     m_hq[i].delete();
                  end
               end
            end
         end
      end
   end

   always @(negedge clk) begin
      if (m_ready) begin
         for (int i = 0; i < 3; i++) begin
            check("locked",      i, 32'(locked_w[i]), 32'(m_lock[i]));
            check("data",        i, 32'(data_w[i]),   32'(e_data[i]));
            check("data_valid",  i, 32'(valid_w[i]),  32'(e_valid[i]));
            check("frame_done",  i, 32'(done_w[i]),   32'(e_done[i]));
            check("frame_count", i, 32'(count_w[i]),  32'(e_cnt[i]));
         end
      end
   end

   task automatic send_bits(input int idx, input logic [31:0] v, input int n);
      for (int b = n - 1; b >= 0; b--) begin
         in_v[idx] = v[b];
         @(posedge clk);
         #1;
      end
   endtask

   task automatic pulse_reset();
      reset = 1'b1;
      @(posedge clk);
      #1;
      reset = 1'b0;
   endtask

   initial begin
      int first_lock;
      for (int i = 0; i < 3; i++) in_v[i] = 1'b0;
      reset = 1'b1;
      @(posedge clk);
      @(posedge clk);
      #1;
      reset = 1'b0;

      // SYNC=00: the eighth sampled zero completes the first sync.
      first_lock = 0;
      for (int i = 1; i <= 20; i++) begin
         @(posedge clk);
         #1;
         if (locked_w[1] && first_lock == 0) first_lock = i;
      end
      check("zero_sync_lock_edge", 1, 32'(first_lock), 32'd8);

      // Basic frame A5 3C F0.
      pulse_reset();
      check("reset_count", 0, 32'(count_w[0]), 32'd0);
      check("reset_locked", 0, 32'(locked_w[0]), 32'd0);
      send_bits(0, 32'hA5, 8);
      check("lock_after_sync", 0, 32'(locked_w[0]), 32'd1);
      send_bits(0, 32'h3C, 8);
      check("byte0_valid", 0, 32'(valid_w[0]), 32'd1);
      check("byte0_data", 0, 32'(data_w[0]), 32'h3C);
      check("byte0_not_done", 0, 32'(done_w[0]), 32'd0);
      send_bits(0, 32'hF0, 8);
      check("byte1_data", 0, 32'(data_w[0]), 32'hF0);
      check("byte1_done", 0, 32'(done_w[0]), 32'd1);
      check("frame_count_1", 0, 32'(count_w[0]), 32'd1);
      check("unlock_at_done", 0, 32'(locked_w[0]), 32'd0);
      @(posedge clk);
      #1;
      check("data_holds", 0, 32'(data_w[0]), 32'hF0);
      check("valid_one_cycle", 0, 32'(valid_w[0]), 32'd0);

      // Sync at bit offset 3 after arbitrary bits.
      pulse_reset();
      send_bits(0, 32'b101, 3);
      send_bits(0, 32'h52, 7);
      check("offset_not_early", 0, 32'(locked_w[0]), 32'd0);
      send_bits(0, 32'h1, 1);
      check("offset_lock", 0, 32'(locked_w[0]), 32'd1);
      send_bits(0, 32'h12, 8);
      check("offset_byte0", 0, 32'(data_w[0]), 32'h12);
      send_bits(0, 32'h34, 8);
      check("offset_byte1", 0, 32'(data_w[0]), 32'h34);
      check("offset_done", 0, 32'(done_w[0]), 32'd1);

      // Sync pattern inside payload is data.
      pulse_reset();
      send_bits(0, 32'hA5, 8);
      send_bits(0, 32'hA5, 8);
      check("sync_as_data0", 0, 32'(data_w[0]), 32'hA5);
      check("still_locked", 0, 32'(locked_w[0]), 32'd1);
      check("no_early_done", 0, 32'(done_w[0]), 32'd0);
      send_bits(0, 32'hA5, 8);
      check("sync_as_data1_done", 0, 32'(done_w[0]), 32'd1);
      check("sync_as_data_count", 0, 32'(count_w[0]), 32'd1);

      // Reset during bit 5 of the second payload byte.
      pulse_reset();
      send_bits(0, 32'hA5, 8);
      send_bits(0, 32'h11, 8);
      send_bits(0, 32'h22 >> 3, 5);
      pulse_reset();
      check("abort_locked", 0, 32'(locked_w[0]), 32'd0);
      check("abort_count", 0, 32'(count_w[0]), 32'd0);
      check("abort_valid", 0, 32'(valid_w[0]), 32'd0);
      send_bits(0, 32'h2, 3);
      send_bits(0, 32'hA5, 8);
      send_bits(0, 32'h66, 8);
      check("after_abort_byte0", 0, 32'(data_w[0]), 32'h66);
      send_bits(0, 32'h77, 8);
      check("after_abort_byte1", 0, 32'(data_w[0]), 32'h77);
      check("after_abort_count", 0, 32'(count_w[0]), 32'd1);

      // 256 back-to-back single-byte frames.
      pulse_reset();
      for (int f = 0; f < 256; f++) begin
         send_bits(2, 32'hA5 >> 1, 7);
         check("b2b_not_early", 2, 32'(locked_w[2]), 32'd0);
         send_bits(2, 32'h1, 1);
         check("b2b_lock", 2, 32'(locked_w[2]), 32'd1);
         send_bits(2, 32'(f), 8);
         check("b2b_done", 2, 32'(done_w[2]), 32'd1);
         check("b2b_data", 2, 32'(data_w[2]), 32'(f[7:0]));
         check("b2b_count", 2, 32'(count_w[2]), 32'((f + 1) % 256));
      end
      check("b2b_wrap", 2, 32'(count_w[2]), 32'd0);

      repeat (4) @(posedge clk);
      #1;
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
